// File: rtl/cpu.sv
// Four-stage (IF/ID/EX/WB) 16-bit CPU with 64K-word instruction and data memories.
// Define CPU_FORWARDING_EN to forward WB results into EX instead of stalling on dependencies.

module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);
  logic [15:0] MEM [0:14];
  logic [15:0] r15;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) MEM[i] <= '0;
      r15 <= '0;
    end else if (we) begin
      if (waddr == 4'd15) r15 <= wdata;
      else MEM[waddr] <= wdata;
    end
  end

  // Write-through lets ID see the value WB is committing this same cycle.
  always_comb begin
    rdata_a = (raddr_a == 4'd15) ? r15 : MEM[raddr_a];
    rdata_b = (raddr_b == 4'd15) ? r15 : MEM[raddr_b];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
  end
endmodule

module cpu_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module cpu #(
  parameter string IMEM_FILE = "imem.hex"
) (
  input logic clk,
  input logic reset
);
  localparam logic [4:0] OP_ADD  = 5'b00001, OP_SUB  = 5'b00010, OP_AND  = 5'b00011,
                         OP_OR   = 5'b00100, OP_XOR  = 5'b00101, OP_SLL  = 5'b00110,
                         OP_SRL  = 5'b00111, OP_MOV  = 5'b01000, OP_ADDI = 5'b01001,
                         OP_LI   = 5'b01010, OP_LD   = 5'b01100, OP_ST   = 5'b01101,
                         OP_BEQZ = 5'b01110, OP_BNEZ = 5'b01111, OP_JMP  = 5'b10000,
                         OP_JAL  = 5'b10001, OP_JR   = 5'b10010, OP_HALT = 5'b11100;
  localparam logic [15:0] NOP = 16'h0000;

  function automatic logic writes_reg(input logic [4:0] op);
    return (op >= OP_ADD && op <= OP_LI) || op == OP_LD || op == OP_JAL;
  endfunction

  function automatic logic [3:0] dest_of(input logic [15:0] ins);
    return (ins[15:11] == OP_JAL) ? 4'd15 : ins[10:7];
  endfunction

  logic [15:0] imem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = '0;
  end

  logic [15:0] pc_reg;
  logic [15:0] id_instr_reg, id_pc_reg;
  logic [15:0] ex_instr_reg, ex_pc_reg, ex_a_reg, ex_b_reg;
  logic [15:0] instr, wb_result_reg;
  logic [3:0]  wb_rd_reg;
  logic        wb_we_reg;
  logic        halt_pending_reg;

  logic        halted;
  assign halted = (instr[15:11] == OP_HALT);

  // ID stage
  logic [4:0]  id_op;
  logic [3:0]  id_rd, id_rs;
  logic [15:0] rf_a, rf_b;
  logic        id_is_halt, id_stall;
  assign id_op      = id_instr_reg[15:11];
  assign id_rd      = id_instr_reg[10:7];
  assign id_rs      = id_instr_reg[6:3];
  assign id_is_halt = (id_op == OP_HALT);

  cpu_regfile registers (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we_reg),
    .waddr   (wb_rd_reg),
    .wdata   (wb_result_reg),
    .raddr_a (id_rd),
    .raddr_b (id_rs),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // EX stage
  logic [4:0]  ex_op;
  logic [3:0]  ex_rd, ex_rs, ex_dest;
  logic [15:0] ex_imm, ex_off, op_a, op_b, ex_result, ex_target, dmem_rdata;
  logic        ex_we, ex_taken;
  assign ex_op   = ex_instr_reg[15:11];
  assign ex_rd   = ex_instr_reg[10:7];
  assign ex_rs   = ex_instr_reg[6:3];
  assign ex_imm  = {{9{ex_instr_reg[6]}}, ex_instr_reg[6:0]};
  assign ex_off  = {{5{ex_instr_reg[10]}}, ex_instr_reg[10:0]};
  assign ex_we   = writes_reg(ex_op);
  assign ex_dest = dest_of(ex_instr_reg);

`ifdef CPU_FORWARDING_EN
  assign op_a     = (wb_we_reg && wb_rd_reg == ex_rd) ? wb_result_reg : ex_a_reg;
  assign op_b     = (wb_we_reg && wb_rd_reg == ex_rs) ? wb_result_reg : ex_b_reg;
  assign id_stall = 1'b0;
`else
  logic id_reads_rd, id_reads_rs;
  assign op_a = ex_a_reg;
  assign op_b = ex_b_reg;
  assign id_reads_rd = (id_op >= OP_ADD && id_op <= OP_SRL) || id_op == OP_ADDI ||
                       id_op == OP_ST || id_op == OP_BEQZ || id_op == OP_BNEZ || id_op == OP_JR;
  assign id_reads_rs = (id_op >= OP_ADD && id_op <= OP_MOV) || id_op == OP_LD || id_op == OP_ST;
  // One bubble is enough: after it the producer sits in WB and write-through covers the read.
  assign id_stall = ex_we && ((id_reads_rd && id_rd == ex_dest) || (id_reads_rs && id_rs == ex_dest));
`endif

  cpu_dmem dataMemory (
    .clk   (clk),
    .we    ((ex_op == OP_ST) && !halted),
    .addr  (op_b),
    .wdata (op_a),
    .rdata (dmem_rdata)
  );

  always_comb begin
    ex_result = '0;
    ex_taken  = 1'b0;
    ex_target = ex_pc_reg + 16'd1 + ex_imm;
    case (ex_op)
      OP_ADD:  ex_result = op_a + op_b;
      OP_SUB:  ex_result = op_a - op_b;
      OP_AND:  ex_result = op_a & op_b;
      OP_OR:   ex_result = op_a | op_b;
      OP_XOR:  ex_result = op_a ^ op_b;
      OP_SLL:  ex_result = op_a << op_b[3:0];
      OP_SRL:  ex_result = op_a >> op_b[3:0];
      OP_MOV:  ex_result = op_b;
      OP_ADDI: ex_result = op_a + ex_imm;
      OP_LI:   ex_result = ex_imm;
      OP_LD:   ex_result = dmem_rdata;
      OP_BEQZ: ex_taken  = (op_a == 16'd0);
      OP_BNEZ: ex_taken  = (op_a != 16'd0);
      OP_JMP: begin
        ex_taken  = 1'b1;
        ex_target = ex_pc_reg + 16'd1 + ex_off;
      end
      OP_JAL: begin
        ex_result = ex_pc_reg + 16'd1;
        ex_taken  = 1'b1;
        ex_target = ex_pc_reg + 16'd1 + ex_off;
      end
      OP_JR: begin
        ex_taken  = 1'b1;
        ex_target = op_a;
      end
      default: ;
    endcase
  end

  // Priority: halt freeze, then branch flush, then dependency stall, then HALT drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg           <= '0;
      id_instr_reg     <= NOP;
      id_pc_reg        <= '0;
      ex_instr_reg     <= NOP;
      ex_pc_reg        <= '0;
      ex_a_reg         <= '0;
      ex_b_reg         <= '0;
      instr            <= NOP;
      wb_result_reg    <= '0;
      wb_rd_reg        <= '0;
      wb_we_reg        <= 1'b0;
      halt_pending_reg <= 1'b0;
    end else if (!halted) begin
      instr         <= ex_instr_reg;
      wb_result_reg <= ex_result;
      wb_rd_reg     <= ex_dest;
      wb_we_reg     <= ex_we;
      if (ex_taken) begin
        pc_reg       <= ex_target;
        id_instr_reg <= NOP;
        ex_instr_reg <= NOP;
      end else if (id_stall) begin
        ex_instr_reg <= NOP;
      end else begin
        ex_instr_reg <= id_instr_reg;
        ex_pc_reg    <= id_pc_reg;
        ex_a_reg     <= rf_a;
        ex_b_reg     <= rf_b;
        if (id_is_halt || halt_pending_reg) begin
          id_instr_reg     <= NOP;
          halt_pending_reg <= 1'b1;
        end else begin
          pc_reg       <= pc_reg + 16'd1;
          id_instr_reg <= imem[pc_reg];
          id_pc_reg    <= pc_reg;
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: each program queues its expected final state, a monitor
// compares it when HALT reaches WB.

module tb_cpu;
  localparam logic [4:0] T_ADD = 5'b00001, T_SUB = 5'b00010, T_AND = 5'b00011, T_OR = 5'b00100,
                         T_XOR = 5'b00101, T_SLL = 5'b00110, T_SRL = 5'b00111, T_MOV = 5'b01000,
                         T_ADDI = 5'b01001, T_LI = 5'b01010, T_LD = 5'b01100, T_ST = 5'b01101,
                         T_BEQZ = 5'b01110, T_BNEZ = 5'b01111, T_JMP = 5'b10000, T_JAL = 5'b10001,
                         T_JR = 5'b10010;
  localparam logic [15:0] T_HALT = 16'hE000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cpu #(.IMEM_FILE("")) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 register, 1 memory word, 2 count of nonzero memory words
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] prog_q[$];
  logic [15:0] exp_regs [16];
  string       cur_name;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  function automatic logic [15:0] enc_r(input logic [4:0] op, input int rd, input int rs);
    logic [3:0] d, s;
    d = rd[3:0];
    s = rs[3:0];
    return {op, d, s, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [4:0] op, input int rd, input int imm);
    logic [3:0] d;
    logic [6:0] m;
    d = rd[3:0];
    m = imm[6:0];
    return {op, d, m};
  endfunction

  function automatic logic [15:0] enc_j(input logic [4:0] op, input int off);
    logic [10:0] o;
    o = off[10:0];
    return {op, o};
  endfunction

  function automatic void sb_push(input string n, input int k, input int i, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.idx  = i;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  function automatic logic [15:0] get_reg(input int r);
    return (r < 15) ? dut.registers.MEM[r] : dut.registers.r15;
  endfunction

  task automatic check_val(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", n, act, act, exp, exp);
    end
  endtask

  // Monitor: fires once per run when the WB stage shows HALT.
  initial begin
    bit          seen;
    exp_t        e;
    logic [15:0] act;
    int          cnt;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
      end else if (!seen && dut.instr == T_HALT) begin
        seen = 1'b1;
        while (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          case (e.kind)
            0: act = get_reg(e.idx);
            1: act = dut.dataMemory.mem[e.idx];
            default: begin
              cnt = 0;
              for (int a = 0; a < 65536; a++) if (dut.dataMemory.mem[a] != 16'h0) cnt++;
              act = cnt[15:0];
            end
          endcase
          check_val(e.name, act, e.val);
        end
        $display("program %s: halted at %0t, state compared", cur_name, $time);
        done_cnt++;
      end
    end
  end

  // Holds reset, loads the program and queues the register expectations.
  task automatic prepare(input string name);
    reset = 1'b1;
    @(negedge clk);
    cur_name = name;
    for (int a = 0; a < 256; a++) dut.imem[a] = 16'h0000;
    foreach (prog_q[i]) dut.imem[i] = prog_q[i];
    for (int r = 0; r < 16; r++) sb_push($sformatf("%s r%0d", name, r), 0, r, exp_regs[r]);
    @(negedge clk);
  endtask

  task automatic wait_done(input int start);
    int cyc;
    cyc = 0;
    while (done_cnt == start && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL %s halt-timeout: got no HALT in WB, expected HALT within 2000 cycles", cur_name);
      sb_q.delete();
    end
  endtask

  task automatic run(input string name);
    int start;
    prepare(name);
    start = done_cnt;
    reset = 1'b0;
    wait_done(start);
  endtask

  initial begin
    int start;

    // LI/ADD with a negative immediate
    #1;
    check_val("reset instr", dut.instr, 16'h0000);
    prog_q = {enc_i(T_LI, 1, 5), enc_i(T_LI, 2, -3), enc_r(T_ADD, 1, 2), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[1] = 16'd2;
    exp_regs[2] = 16'd65533;
    run("basic");

    // Back-to-back dependency chain
    prog_q = {enc_i(T_LI, 1, 1), enc_r(T_ADD, 1, 1), enc_r(T_ADD, 1, 1), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[1] = 16'd4;
    run("depchain");

    // Store then load the same address
    prog_q = {enc_i(T_LI, 1, 7), enc_i(T_LI, 2, 20), enc_r(T_ST, 1, 2), enc_r(T_LD, 3, 2),
              enc_r(T_ADD, 3, 3), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[1] = 16'd7;
    exp_regs[2] = 16'd20;
    exp_regs[3] = 16'd14;
    sb_push("memory mem[20]", 1, 20, 16'd7);
    sb_push("memory mem[21]", 1, 21, 16'd0);
    sb_push("memory nonzero-words", 2, 0, 16'd1);
    run("memory");

    // Taken BEQZ skips one instruction
    prog_q = {enc_i(T_LI, 1, 0), enc_i(T_BEQZ, 1, 1), enc_i(T_LI, 2, 9), enc_i(T_LI, 3, 4), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[3] = 16'd4;
    run("beqz");

    // Not-taken BNEZ falls through
    prog_q = {enc_i(T_LI, 1, 0), enc_i(T_BNEZ, 1, 1), enc_i(T_LI, 2, 9), enc_i(T_LI, 3, 4), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[2] = 16'd9;
    exp_regs[3] = 16'd4;
    run("bnez");

    // JAL at address 3 links 4 and jumps over two LIs to HALT
    prog_q = {16'h0000, 16'h0000, 16'h0000, enc_j(T_JAL, 2), enc_i(T_LI, 2, 1),
              enc_i(T_LI, 3, 1), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[15] = 16'd4;
    run("jal");

    // HALT right behind a taken JMP is flushed
    prog_q = {enc_i(T_LI, 1, 1), enc_j(T_JMP, 1), T_HALT, enc_i(T_LI, 5, 3), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[1] = 16'd1;
    exp_regs[5] = 16'd3;
    run("jmp-halt");

    // JR through a just-written register
    prog_q = {enc_i(T_LI, 4, 4), enc_r(T_JR, 4, 0), enc_i(T_LI, 6, 1), enc_i(T_LI, 6, 2),
              enc_i(T_LI, 7, 5), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[4] = 16'd4;
    exp_regs[7] = 16'd5;
    run("jr");

    // ALU operations and shifts
    prog_q = {enc_i(T_LI, 1, 53), enc_i(T_LI, 2, 15),
              enc_r(T_MOV, 3, 1), enc_r(T_AND, 3, 2),
              enc_r(T_MOV, 4, 1), enc_r(T_OR, 4, 2),
              enc_r(T_MOV, 5, 1), enc_r(T_XOR, 5, 2),
              enc_r(T_MOV, 6, 1), enc_r(T_SUB, 6, 2),
              enc_i(T_LI, 7, 4), enc_r(T_MOV, 8, 1), enc_r(T_SLL, 8, 7),
              enc_i(T_LI, 9, -32), enc_r(T_SRL, 9, 7), enc_i(T_ADDI, 9, -2), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[1] = 16'd53;
    exp_regs[2] = 16'd15;
    exp_regs[3] = 16'd5;
    exp_regs[4] = 16'd63;
    exp_regs[5] = 16'd58;
    exp_regs[6] = 16'd38;
    exp_regs[7] = 16'd4;
    exp_regs[8] = 16'd848;
    exp_regs[9] = 16'd4092;
    run("alu");

    // Countdown loop, interrupted by reset five cycles in, then rerun to completion
    prog_q = {enc_i(T_LI, 1, 5), enc_i(T_LI, 2, 0), enc_i(T_ADDI, 2, 1), enc_i(T_ADDI, 1, -1),
              enc_i(T_BNEZ, 1, -3), T_HALT};
    exp_regs = '{default: 16'h0};
    exp_regs[2] = 16'd5;
    prepare("loop-reset");
    start = done_cnt;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("loop-reset instr-in-reset", dut.instr, 16'h0000);
    for (int r = 0; r < 16; r++) check_val($sformatf("loop-reset r%0d-in-reset", r), get_reg(r), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(start);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
